// File: rtl/ram_slot_arbiter_pkg.sv
// Shared types for the RAM slot arbiter: owner codes and counter sizing.
package ram_slot_arbiter_pkg;

   // Who currently owns the RAM slot.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_DMA  = 2'd3
   } owner_e;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ram_slot_timer.sv
// Slot timing for the RAM arbiter: phase counts clocks inside a slot, slot
// counts slots inside the video period. Slot 0 is the video slot.
module ram_slot_timer
   import ram_slot_arbiter_pkg::*;
#(
   parameter int SLOT_LEN  = 4,
   parameter int RD_LAT    = 2,
   parameter int VID_EVERY = 2
) (
   input  logic clk,
   input  logic reset,
   output logic grant_stb,
   output logic data_stb,
   output logic vid_slot
);

   localparam int PW = cnt_w(SLOT_LEN);
   localparam int SW = cnt_w(VID_EVERY);

   logic [PW-1:0] phase_q, phase_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          wrap;

   // Next phase/slot: phase wraps at SLOT_LEN-1, slot advances on the wrap.
   always_comb begin
      wrap    = (phase_q == PW'(SLOT_LEN - 1));
      phase_d = wrap ? '0 : phase_q + 1'b1;
      slot_d  = slot_q;
      if (wrap)
         slot_d = (slot_q == SW'(VID_EVERY - 1)) ? '0 : slot_q + 1'b1;
   end

   // Counter registers; reset lands on phase 0 of the video slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         slot_q  <= '0;
      end else begin
         phase_q <= phase_d;
         slot_q  <= slot_d;
      end
   end

   assign grant_stb = (phase_q == '0);
   assign data_stb  = (phase_q == PW'(RD_LAT));
   assign vid_slot  = (slot_q == '0);

endmodule

// File: rtl/ram_slot_arbiter.sv
// Time-slot arbiter for the single external RAM port shared by video fetch,
// the Z80 and supervisor DMA. Grants are taken on phase 0 of each slot; the
// owner is acked RD_LAT clocks later with read data captured at that edge.
// Build option: define RAM_ARB_DMA_EN to let DMA share non-video slots with
// the CPU in round-robin; otherwise DMA is ignored and the CPU takes them all.
module ram_slot_arbiter
   import ram_slot_arbiter_pkg::*;
#(
   parameter int AW        = 19,
   parameter int DW        = 8,
   parameter int SLOT_LEN  = 4,
   parameter int RD_LAT    = 2,
   parameter int VID_EVERY = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_wait,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_rdata,
   output logic          vid_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   logic grant_stb, data_stb, vid_slot;

   ram_slot_timer #(
      .SLOT_LEN (SLOT_LEN),
      .RD_LAT   (RD_LAT),
      .VID_EVERY(VID_EVERY)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .grant_stb(grant_stb),
      .data_stb (data_stb),
      .vid_slot (vid_slot)
   );

   owner_e        win;
   owner_e        owner_q, owner_d;
   logic          ram_cs_q, ram_cs_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          vid_ack_q, vid_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] vid_rdata_q, vid_rdata_d;

`ifdef RAM_ARB_DMA_EN
   logic          dma_ack_q, dma_ack_d;
   logic [DW-1:0] dma_rdata_q, dma_rdata_d;
   logic          rr_q, rr_d;        // 0: CPU wins the next tie, 1: DMA
`else
   logic          unused_dma;
   assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_wdata};
`endif

   // Winner selection, evaluated only on the grant phase. An idle video
   // slot falls through to the CPU/DMA rule.
   always_comb begin
      win = OWN_NONE;
`ifdef RAM_ARB_DMA_EN
      rr_d = rr_q;
`endif
      if (grant_stb) begin
         if (vid_slot && vid_req) begin
            win = OWN_VID;
         end else begin
`ifdef RAM_ARB_DMA_EN
            if (cpu_req && dma_req) begin
               win  = rr_q ? OWN_DMA : OWN_CPU;
               rr_d = ~rr_q;
            end else if (cpu_req) begin
               win = OWN_CPU;
            end else if (dma_req) begin
               win = OWN_DMA;
            end
`else
            if (cpu_req) win = OWN_CPU;
`endif
         end
      end
   end

   // Data path: ack/capture on the data phase, launch the RAM cycle on grant.
   // The two phases never coincide because RD_LAT >= 1.
   always_comb begin
      owner_d     = owner_q;
      ram_cs_d    = 1'b0;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      vid_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;
`ifdef RAM_ARB_DMA_EN
      dma_ack_d   = 1'b0;
      dma_rdata_d = dma_rdata_q;
`endif

      if (data_stb && owner_q != OWN_NONE) begin
         case (owner_q)
            OWN_VID: begin
               vid_ack_d   = 1'b1;
               vid_rdata_d = ram_rdata;
            end
            OWN_CPU: begin
               cpu_ack_d = 1'b1;
               if (!ram_we_q) cpu_rdata_d = ram_rdata;
            end
`ifdef RAM_ARB_DMA_EN
            OWN_DMA: begin
               dma_ack_d = 1'b1;
               if (!ram_we_q) dma_rdata_d = ram_rdata;
            end
`endif
            default: ;
         endcase
         owner_d = OWN_NONE;
      end

      if (win != OWN_NONE) begin
         owner_d  = win;
         ram_cs_d = 1'b1;
         case (win)
            OWN_VID: begin
               ram_we_d   = 1'b0;
               ram_addr_d = vid_addr;
            end
            OWN_CPU: begin
               ram_we_d    = cpu_we;
               ram_addr_d  = cpu_addr;
               ram_wdata_d = cpu_wdata;
            end
`ifdef RAM_ARB_DMA_EN
            OWN_DMA: begin
               ram_we_d    = dma_we;
               ram_addr_d  = dma_addr;
               ram_wdata_d = dma_wdata;
            end
`endif
            default: ;
         endcase
      end
   end

   // State registers; reset aborts any slot in flight without an ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q     <= OWN_NONE;
         ram_cs_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         owner_q     <= owner_d;
         ram_cs_q    <= ram_cs_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_ack_q   <= vid_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

`ifdef RAM_ARB_DMA_EN
   // DMA result registers and the CPU/DMA tie-break pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dma_ack_q   <= 1'b0;
         dma_rdata_q <= '0;
         rr_q        <= 1'b0;
      end else begin
         dma_ack_q   <= dma_ack_d;
         dma_rdata_q <= dma_rdata_d;
         rr_q        <= rr_d;
      end
   end

   assign dma_ack   = dma_ack_q;
   assign dma_rdata = dma_rdata_q;
`else
   assign dma_ack   = 1'b0;
   assign dma_rdata = '0;
`endif

   assign ram_cs    = ram_cs_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign vid_ack   = vid_ack_q;
   assign vid_rdata = vid_rdata_q;
   assign cpu_wait  = cpu_req & ~cpu_ack_q;

endmodule
